// File: rtl/gauss_filter_3x3_pkg.sv
// Shared constants and helpers for the 3x3 Gaussian smoothing stage.
// Kernel [1 2 1;2 4 2;1 2 1]/16 is applied separably as row sums then a column sum.
package gauss_filter_3x3_pkg;

    localparam int PIX_W      = 8;
    localparam int ROW_W      = 10;
    localparam int SUM_W      = 12;
    localparam int K_OUTER_SH = 0;
    localparam int K_INNER_SH = 1;
    localparam int ROUND_BIAS = 8;
    localparam int NORM_SHIFT = 4;
    localparam int LATENCY    = 4;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // One kernel row [1 2 1]; max 4*255 = 1020 fits ROW_W.
    function automatic logic [ROW_W-1:0] row_sum(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b,
        input logic [PIX_W-1:0] c
    );
        return (ROW_W'(a) << K_OUTER_SH) + (ROW_W'(b) << K_INNER_SH) + (ROW_W'(c) << K_OUTER_SH);
    endfunction

endpackage

// File: rtl/gauss_filter_3x3_if.sv
// Video stream bundle into and out of the Gaussian stage.
// master drives gray_* and observes filter_*; slave is the filter itself.
interface gauss_filter_3x3_if
    import gauss_filter_3x3_pkg::*;
#(
    parameter int DATA_W = PIX_W
);
    logic [DATA_W-1:0] gray_in;
    logic              gray_de;
    logic              gray_hs;
    logic              gray_vs;
    logic [DATA_W-1:0] filter_out;
    logic              filter_de;
    logic              filter_hs;
    logic              filter_vs;

    modport master (
        output gray_in, gray_de, gray_hs, gray_vs,
        input  filter_out, filter_de, filter_hs, filter_vs
    );

    modport slave (
        input  gray_in, gray_de, gray_hs, gray_vs,
        output filter_out, filter_de, filter_hs, filter_vs
    );
endinterface

// File: rtl/gauss_filter_3x3_line_buffer.sv
// Single-row pixel delay (gauss_line_buffer): simple dual-port RAM, read-before-write.
// The read is asynchronous so the tap is the previous line's pixel at the address being written.
module gauss_line_buffer
    import gauss_filter_3x3_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int DATA_W = PIX_W,
    parameter int PTR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_s,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);
    logic [DATA_W-1:0] r_mem [2**PTR_W];
    logic [PTR_W-1:0]  r_ptr;

    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

    // Pointer restarts at 0 for every line, so short lines stay column-aligned.
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_ptr <= '0;
        end else if (i_clr || !i_en) begin
            r_ptr <= '0;
        end else if (r_ptr == PTR_W'(DEPTH - 1)) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= r_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/gauss_filter_3x3.sv
// 3x3 Gaussian smoothing ahead of the Canny stage: two line buffers, window, 3-stage adder pipeline.
// Optional macro GAUSS_BORDER_ZERO_EN zeroes outputs whose window is incomplete (first 2 rows / cols).
module gauss_filter_3x3
    import gauss_filter_3x3_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = PIX_W,
    parameter int PTR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_s,
    gauss_filter_3x3_if.slave bus
);
    logic [DATA_W-1:0]      w_tap1;
    logic [DATA_W-1:0]      w_tap2;
    logic                   w_clr;
    logic                   w_de_rise;
    logic [SUM_W-1:0]       w_rounded;
    logic [DATA_W-1:0]      w_pix_next;
    sync_t                  w_sync_in;

    logic [2:0][DATA_W-1:0] r_top;
    logic [2:0][DATA_W-1:0] r_mid;
    logic [2:0][DATA_W-1:0] r_bot;
    logic [ROW_W-1:0]       r_row_top;
    logic [ROW_W-1:0]       r_row_mid;
    logic [ROW_W-1:0]       r_row_bot;
    logic [SUM_W-1:0]       r_sum;
    logic [DATA_W-1:0]      r_pix;
    sync_t [LATENCY-1:0]    r_sync;
    logic                   r_de_d;
    logic [PTR_W-1:0]       r_col_cnt;
    logic [PTR_W-1:0]       r_row_cnt;

    assign w_clr     = ~bus.gray_vs;
    assign w_de_rise = bus.gray_de & ~r_de_d;
    assign w_sync_in = '{de: bus.gray_de, hs: bus.gray_hs, vs: bus.gray_vs};

    gauss_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_lb1 (
        .clk    (clk),
        .rst_s  (rst_s),
        .i_en   (bus.gray_de),
        .i_clr  (w_clr),
        .i_din  (bus.gray_in),
        .o_dout (w_tap1)
    );

    gauss_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_lb2 (
        .clk    (clk),
        .rst_s  (rst_s),
        .i_en   (bus.gray_de),
        .i_clr  (w_clr),
        .i_din  (w_tap1),
        .o_dout (w_tap2)
    );

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_top <= '0;
            r_mid <= '0;
            r_bot <= '0;
        end else if (bus.gray_de) begin
            r_top <= {r_top[1:0], w_tap2};
            r_mid <= {r_mid[1:0], w_tap1};
            r_bot <= {r_bot[1:0], bus.gray_in};
        end
    end

    // S1..S3 run every cycle; during de gaps they just recompute the held window.
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_row_top <= '0;
            r_row_mid <= '0;
            r_row_bot <= '0;
            r_sum     <= '0;
            r_pix     <= '0;
            r_sync    <= '0;
        end else begin
            r_row_top <= row_sum(r_top[2], r_top[1], r_top[0]);
            r_row_mid <= row_sum(r_mid[2], r_mid[1], r_mid[0]);
            r_row_bot <= row_sum(r_bot[2], r_bot[1], r_bot[0]);
            r_sum     <= (SUM_W'(r_row_top) << K_OUTER_SH) + (SUM_W'(r_row_mid) << K_INNER_SH)
                         + (SUM_W'(r_row_bot) << K_OUTER_SH);
            r_pix     <= w_pix_next;
            r_sync    <= {r_sync[LATENCY-2:0], w_sync_in};
        end
    end

    // Max sum 4080 + bias stays below 4096, so the shifted result always fits DATA_W.
    assign w_rounded = r_sum + SUM_W'(ROUND_BIAS);

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_de_d    <= 1'b0;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else begin
            r_de_d <= bus.gray_de;
            if (!bus.gray_vs || !bus.gray_de) begin
                r_col_cnt <= '0;
            end else if (r_col_cnt != '1) begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
            if (!bus.gray_vs) begin
                r_row_cnt <= '0;
            end else if (w_de_rise && r_row_cnt != '1) begin
                r_row_cnt <= r_row_cnt + 1'b1;
            end
        end
    end

`ifdef GAUSS_BORDER_ZERO_EN
    logic w_border;
    logic r_mask_w;
    logic r_mask_s1;
    logic r_mask_s2;

    // row_cnt is bumped on the first pixel of a line, so it lags by one on that cycle only.
    assign w_border = (r_col_cnt < PTR_W'(2)) ||
                      (w_de_rise ? (r_row_cnt < PTR_W'(2)) : (r_row_cnt < PTR_W'(3)));

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_mask_w  <= 1'b0;
            r_mask_s1 <= 1'b0;
            r_mask_s2 <= 1'b0;
        end else begin
            if (bus.gray_de) begin
                r_mask_w <= w_border;
            end
            r_mask_s1 <= r_mask_w;
            r_mask_s2 <= r_mask_s1;
        end
    end

    assign w_pix_next = r_mask_s2 ? '0 : DATA_W'(w_rounded >> NORM_SHIFT);
`else
    assign w_pix_next = DATA_W'(w_rounded >> NORM_SHIFT);
`endif

    assign bus.filter_out = r_pix;
    assign bus.filter_de  = r_sync[LATENCY-1].de;
    assign bus.filter_hs  = r_sync[LATENCY-1].hs;
    assign bus.filter_vs  = r_sync[LATENCY-1].vs;
endmodule

// File: tb/tb_gauss_filter_3x3.sv
// Bench for gauss_filter_3x3 with a narrow 16-pixel line; scoreboard holds one entry per
// driven cycle and pops it four clocks later when the matching output is visible.
module tb_gauss_filter_3x3;
    localparam int W          = 16;
    localparam int HMAX       = 8;
    localparam int PIPE_DEPTH = 4;

    typedef struct {
        int         mode;   // 0 none, 1 exact pixel, 2 pixel must be nonzero
        logic [7:0] pix;
        logic       de, hs, vs;
        int         cr, cc;
    } exp_t;

    typedef struct {
        exp_t       e;
        logic [7:0] pix;
        logic       de, hs, vs;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_s = 1'b0;
    always #5 clk = ~clk;

    gauss_filter_3x3_if #(.DATA_W(8)) bus ();

    gauss_filter_3x3 #(.IMG_WIDTH(W), .DATA_W(8), .PTR_W(4)) dut (
        .clk   (clk),
        .rst_s (rst_s),
        .bus   (bus)
    );

    exp_t       sbq[$];
    rec_t       rec_q[$];
    logic [7:0] img [HMAX][W];
    bit         stale_nz = 1'b0;
    int         n_cmp    = 0;
    int         n_bad    = 0;

    task automatic fill(input int v);
        for (int r = 0; r < HMAX; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'(v);
    endtask

    // Direct 2-D convolution centred one line and one pixel behind input (r,c).
    function automatic logic [7:0] conv(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(img[r-2+i][c-2+j]) * ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1);
        return 8'((s + 8) / 16);
    endfunction

    function automatic exp_t no_chk();
        exp_t e;
        e.mode = 0; e.pix = 8'd0; e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.cr = -9; e.cc = -9;
        return e;
    endfunction

    function automatic exp_t expect_pix(input int r, input int c);
        exp_t e = no_chk();
        e.cr = r - 1;
        e.cc = c - 1;
`ifdef GAUSS_BORDER_ZERO_EN
        e.mode = 1;
        e.pix  = (r < 2 || c < 2) ? 8'd0 : conv(r, c);
`else
        if (r >= 2 && c >= 2) begin
            e.mode = 1;
            e.pix  = conv(r, c);
        end else if (stale_nz && r == 0 && c >= 2) begin
            e.mode = 2;
        end
`endif
        return e;
    endfunction

    // Called at a falling edge: collect the output due now, drive this cycle, push its expectation.
    task automatic tick(input logic [7:0] pix, input logic de, input logic hs, input logic vs, input exp_t e);
        rec_t r;
        if (sbq.size() == PIPE_DEPTH) begin
            r.e   = sbq.pop_front();
            r.pix = bus.filter_out;
            r.de  = bus.filter_de;
            r.hs  = bus.filter_hs;
            r.vs  = bus.filter_vs;
            rec_q.push_back(r);
        end
        bus.gray_in = pix;
        bus.gray_de = de;
        bus.gray_hs = hs;
        bus.gray_vs = vs;
        e.de = de; e.hs = hs; e.vs = vs;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_frame(input int h, input int abort_row);
        repeat (3) tick(8'd0, 1'b0, 1'b0, 1'b0, no_chk());
        repeat (2) tick(8'd0, 1'b0, 1'b0, 1'b1, no_chk());
        for (int r = 0; r < h; r++) begin
            for (int g = 0; g < 4; g++) tick(8'd0, 1'b0, g < 2, 1'b1, no_chk());
            for (int c = 0; c < W; c++) begin
                if (r == abort_row && c == W / 2) return;
                tick(img[r][c], 1'b1, 1'b0, 1'b1, expect_pix(r, c));
            end
        end
        repeat (6) tick(8'd0, 1'b0, 1'b0, 1'b1, no_chk());
    endtask

    task automatic test_reset();
        rst_s = 1'b0;
        bus.gray_in = 8'd55; bus.gray_de = 1'b1; bus.gray_hs = 1'b1; bus.gray_vs = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.filter_out, bus.filter_de, bus.filter_hs, bus.filter_vs} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got out=%0d de=%b hs=%b vs=%b required all 0",
                     bus.filter_out, bus.filter_de, bus.filter_hs, bus.filter_vs);
        end
        bus.gray_de = 1'b0; bus.gray_hs = 1'b0; bus.gray_vs = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        sbq.delete();
        rec_q.delete();
    endtask

    task automatic test_flat();
        fill(100);
        rec_q.delete();
        run_frame(8, -1);
        foreach (rec_q[k]) if (rec_q[k].e.mode == 1) begin
            n_cmp++;
            if (rec_q[k].pix !== rec_q[k].e.pix) begin
                n_bad++;
                $display("FAIL flat_pix(%0d,%0d): got %0d required %0d",
                         rec_q[k].e.cr, rec_q[k].e.cc, rec_q[k].pix, rec_q[k].e.pix);
            end
        end
    endtask

    task automatic test_impulse();
        bit found;
        logic [7:0] got;
        fill(0);
        img[5][10] = 8'd160;
        rec_q.delete();
        run_frame(8, -1);
        foreach (rec_q[k]) if (rec_q[k].e.mode == 1) begin
            n_cmp++;
            if (rec_q[k].pix !== rec_q[k].e.pix) begin
                n_bad++;
                $display("FAIL impulse_pix(%0d,%0d): got %0d required %0d",
                         rec_q[k].e.cr, rec_q[k].e.cc, rec_q[k].pix, rec_q[k].e.pix);
            end
        end
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                found = 1'b0;
                got   = 8'hxx;
                foreach (rec_q[k])
                    if (rec_q[k].e.mode == 1 && rec_q[k].e.cr == 5 + dr && rec_q[k].e.cc == 10 + dc) begin
                        found = 1'b1;
                        got   = rec_q[k].pix;
                    end
                n_cmp++;
                if (!found || got !== 8'(40 >> ((dr < 0 ? -dr : dr) + (dc < 0 ? -dc : dc)))) begin
                    n_bad++;
                    $display("FAIL impulse_tap(%0d,%0d): got %0d required %0d", dr, dc, got,
                             40 >> ((dr < 0 ? -dr : dr) + (dc < 0 ? -dc : dc)));
                end
            end
        end
    endtask

    task automatic test_rounding();
        logic [7:0] got24;
        logic [7:0] got23;
        for (int f = 0; f < 3; f++) begin
            if (f == 0) begin
                fill(0);
                img[4][5]  = 8'd6;
                img[4][12] = 8'd5;
                img[3][12] = 8'd1;
                img[3][11] = 8'd1;
            end else begin
                fill(f == 1 ? 255 : 0);
            end
            rec_q.delete();
            run_frame(f == 0 ? 8 : 4, -1);
            got24 = 8'hxx;
            got23 = 8'hxx;
            foreach (rec_q[k]) if (rec_q[k].e.mode == 1) begin
                if (rec_q[k].e.cr == 4 && rec_q[k].e.cc == 5)  got24 = rec_q[k].pix;
                if (rec_q[k].e.cr == 4 && rec_q[k].e.cc == 12) got23 = rec_q[k].pix;
                n_cmp++;
                if (rec_q[k].pix !== rec_q[k].e.pix) begin
                    n_bad++;
                    $display("FAIL round_frame%0d(%0d,%0d): got %0d required %0d", f,
                             rec_q[k].e.cr, rec_q[k].e.cc, rec_q[k].pix, rec_q[k].e.pix);
                end
            end
            if (f == 0) begin
                n_cmp += 2;
                if (got24 !== 8'd2) begin
                    n_bad++;
                    $display("FAIL round_sum24: got %0d required 2", got24);
                end
                if (got23 !== 8'd1) begin
                    n_bad++;
                    $display("FAIL round_sum23: got %0d required 1", got23);
                end
            end
        end
    endtask

    task automatic test_sync();
        logic de, hs, vs;
        vs = 1'b1;
        rec_q.delete();
        repeat (300) begin
            de = 1'($urandom_range(0, 1));
            hs = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) vs = ~vs;
            tick(8'($urandom_range(0, 255)), de, hs, vs, no_chk());
        end
        repeat (PIPE_DEPTH + 1) tick(8'd0, 1'b0, 1'b0, 1'b0, no_chk());
        foreach (rec_q[k]) begin
            n_cmp++;
            if ({rec_q[k].de, rec_q[k].hs, rec_q[k].vs} !== {rec_q[k].e.de, rec_q[k].e.hs, rec_q[k].e.vs}) begin
                n_bad++;
                $display("FAIL sync_delay[%0d]: got de/hs/vs=%b%b%b required %b%b%b", k,
                         rec_q[k].de, rec_q[k].hs, rec_q[k].vs, rec_q[k].e.de, rec_q[k].e.hs, rec_q[k].e.vs);
            end
        end
    endtask

    task automatic test_border();
        fill(200);
        stale_nz = 1'b1;
        rec_q.delete();
        run_frame(4, -1);
        stale_nz = 1'b0;
        foreach (rec_q[k]) begin
            if (rec_q[k].e.mode == 1) begin
                n_cmp++;
                if (rec_q[k].pix !== rec_q[k].e.pix) begin
                    n_bad++;
                    $display("FAIL border_pix(%0d,%0d): got %0d required %0d",
                             rec_q[k].e.cr, rec_q[k].e.cc, rec_q[k].pix, rec_q[k].e.pix);
                end
            end else if (rec_q[k].e.mode == 2) begin
                n_cmp++;
                if (rec_q[k].pix === 8'd0 || $isunknown(rec_q[k].pix)) begin
                    n_bad++;
                    $display("FAIL border_stale(%0d,%0d): got %0d required nonzero",
                             rec_q[k].e.cr, rec_q[k].e.cc, rec_q[k].pix);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        fill(100);
        rec_q.delete();
        run_frame(8, 3);
        rst_s = 1'b0;
        for (int t = 0; t < 3; t++) begin
            if (t == 0) #1; else @(negedge clk);
            n_cmp++;
            if ({bus.filter_out, bus.filter_de, bus.filter_hs, bus.filter_vs} !== 11'd0) begin
                n_bad++;
                $display("FAIL midframe_reset_t%0d: got out=%0d de=%b hs=%b vs=%b required all 0", t,
                         bus.filter_out, bus.filter_de, bus.filter_hs, bus.filter_vs);
            end
        end
        rst_s = 1'b1;
        sbq.delete();
        rec_q.delete();
        run_frame(8, -1);
        foreach (rec_q[k]) if (rec_q[k].e.mode == 1) begin
            n_cmp++;
            if (rec_q[k].pix !== rec_q[k].e.pix) begin
                n_bad++;
                $display("FAIL after_reset_pix(%0d,%0d): got %0d required %0d",
                         rec_q[k].e.cr, rec_q[k].e.cc, rec_q[k].pix, rec_q[k].e.pix);
            end
        end
    endtask

    initial begin
        bus.gray_in = 8'd0;
        bus.gray_de = 1'b0;
        bus.gray_hs = 1'b0;
        bus.gray_vs = 1'b0;
        test_reset();
        test_flat();
        test_impulse();
        test_rounding();
        test_sync();
        test_border();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
